xood_cmd_sequencer: RTL and testbench

Programmable command sequencer that drives the opmode/input-data interface of `xoodyak_build`. It replaces hard-coded per-cycle opmode and data arrays with a loadable command table and a loadable data-word table. It plays the table out to the core under a valid/ready handshake, with a per-command repeat count and optional looping. It sits between the host/bus side and the Xoodyak core and is synthesizable.

---
 rtl/xood_seq_pkg.sv | 29 ++
 rtl/xood_seq_table.sv | 37 +++
 rtl/xood_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_xood_cmd_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xood_seq_pkg.sv
// Shared types and constants for the Xoodyak command sequencer.
package xood_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  // Command-table entry layout for the default parameter set.
  typedef struct packed {
    logic [5:0] opmode;
    logic [3:0] sel;
    logic [3:0] rpt;
    logic       last;
  } seq_entry_t;

  localparam logic [5:0] OP_IDLE     = 6'd0;
  localparam logic [5:0] OP_INIT     = 6'd1;
  localparam logic [5:0] OP_NONCE    = 6'd2;
  localparam logic [5:0] OP_ASSOC    = 6'd3;
  localparam logic [5:0] OP_CRYPT    = 6'd4;
  localparam logic [5:0] OP_DECRYPT  = 6'd5;
  localparam logic [5:0] OP_SQUEEZE  = 6'd6;
  localparam logic [5:0] OP_RATCHET  = 6'd7;
  localparam logic [5:0] OP_CONT_BIT = 6'h20;

endpackage

// File: rtl/xood_seq_table.sv
// Single-write-port register file with a registered read port. A write and a
// read of the same address in one cycle returns the new data (write-through),
// so an entry written in cycle N is visible to a read issued in cycle N.
// Only the read register is reset; the storage array is not.
module xood_seq_table #(
  parameter int W  = 8,
  parameter int N  = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  // Storage array: write-only update, no reset.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < N)) mem[waddr] <= wdata;
  end

  // Read register with write-through forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      if (we && (waddr == raddr))  rdata <= wdata;
      else if (int'(raddr) < N)    rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/xood_cmd_sequencer.sv
// Programmable command sequencer feeding the opmode/data interface of the
// Xoodyak core. Optional feature macro: XOOD_SEQ_LOOP_EN (adds loop_mode input
// that restarts the table from entry 0 after each completed pass).
//
// The command table is read one cycle ahead (addressed by the next pc), so in
// FETCH the entry is already registered and its sel field can address the data
// table, whose read register drives core_data directly.
module xood_cmd_sequencer
  import xood_seq_pkg::*;
#(
  parameter int DATA_W   = 352,
  parameter int OPMODE_W = 6,
  parameter int DEPTH    = 64,
  parameter int NUM_SEL  = 9,
  parameter int RPT_W    = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int SEL_W   = $clog2(NUM_SEL)
) (
  input  logic                eph1,
  input  logic                reset_n,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [OPMODE_W-1:0] prog_opmode,
  input  logic [SEL_W-1:0]    prog_sel,
  input  logic [RPT_W-1:0]    prog_rpt,
  input  logic                prog_last,
  input  logic                data_we,
  input  logic [SEL_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic                start,
  input  logic                abort,
`ifdef XOOD_SEQ_LOOP_EN
  input  logic                loop_mode,
`endif
  input  logic                core_ready,
  output logic                core_valid,
  output logic [OPMODE_W-1:0] core_opmode,
  output logic [DATA_W-1:0]   core_data,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       pc,
  output logic                err
);

  localparam int ENT_W = OPMODE_W + SEL_W + RPT_W + 1;

  seq_state_e          state, state_nxt;
  logic [AW-1:0]       pc_nxt;
  logic [RPT_W-1:0]    rpt_cnt, rpt_q;
  logic                last_q;
  logic                loop_en;
  logic                idle;
  logic                xfer;
  logic [ENT_W-1:0]    cmd_wdata, cmd_rdata;
  logic [OPMODE_W-1:0] ent_opmode;
  logic [SEL_W-1:0]    ent_sel;
  logic [RPT_W-1:0]    ent_rpt;
  logic                ent_last;

`ifdef XOOD_SEQ_LOOP_EN
  assign loop_en = loop_mode;
`else
  assign loop_en = 1'b0;
`endif

  assign idle       = (state == S_IDLE);
  assign xfer       = (state == S_ISSUE) && core_ready;
  assign cmd_wdata  = {prog_opmode, prog_sel, prog_rpt, prog_last};
  assign ent_opmode = cmd_rdata[ENT_W-1 -: OPMODE_W];
  assign ent_sel    = cmd_rdata[RPT_W+1 +: SEL_W];
  assign ent_rpt    = cmd_rdata[1 +: RPT_W];
  assign ent_last   = cmd_rdata[0];

  assign core_valid = (state == S_ISSUE);
  assign busy       = !idle;
  assign done       = (state == S_DONE);

  xood_seq_table #(.W(ENT_W), .N(DEPTH)) u_cmd_tbl (
    .clk   (eph1),
    .rst_n (reset_n),
    .we    (prog_we && idle),
    .waddr (prog_addr),
    .wdata (cmd_wdata),
    .re    (state_nxt == S_FETCH),
    .raddr (pc_nxt),
    .rdata (cmd_rdata)
  );

  xood_seq_table #(.W(DATA_W), .N(NUM_SEL)) u_data_tbl (
    .clk   (eph1),
    .rst_n (reset_n),
    .we    (data_we && idle),
    .waddr (data_addr),
    .wdata (data_wdata),
    .re    (state == S_FETCH),
    .raddr (ent_sel),
    .rdata (core_data)
  );

  // Next-state and next-pc decode; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (xfer && (rpt_cnt == rpt_q)) begin
          if (last_q || (pc == AW'(DEPTH - 1))) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
            pc_nxt    = pc + AW'(1);
          end
        end
      end
      S_DONE: begin
        if (loop_en) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && !idle) begin
      state_nxt = S_IDLE;
      pc_nxt    = pc;
    end
  end

  // State and program-counter registers.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Per-entry beat registers: loaded in FETCH, repeat counter advances per transfer.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      core_opmode <= OPMODE_W'(OP_IDLE);
      rpt_q       <= '0;
      last_q      <= 1'b0;
      rpt_cnt     <= '0;
    end else if (state == S_FETCH) begin
      core_opmode <= ent_opmode;
      rpt_q       <= ent_rpt;
      last_q      <= ent_last;
      rpt_cnt     <= '0;
    end else if (xfer && (rpt_cnt != rpt_q)) begin
      rpt_cnt     <= rpt_cnt + RPT_W'(1);
    end
  end

  // Sticky error for table writes attempted during a run; cleared by a new run.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (idle && start && !abort) begin
      err <= 1'b0;
    end else if (!idle && (prog_we || data_we)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xood_cmd_sequencer.sv
// Directed testbench for xood_cmd_sequencer (DEPTH=8, DATA_W=64).
module tb_xood_cmd_sequencer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;

  localparam logic [63:0] D0  = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] D1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2  = 64'hdead_beef_0000_0002;
  localparam logic [63:0] D3  = 64'hcafe_f00d_0000_0003;
  localparam logic [63:0] D4  = 64'h5a5a_a5a5_0000_0004;
  localparam logic [63:0] BAD = 64'hffff_ffff_ffff_ffff;

  logic        eph1, reset_n;
  logic        prog_we, prog_last, data_we, start, abort, core_ready, loop_mode;
  logic [2:0]  prog_addr;
  logic [5:0]  prog_opmode;
  logic [3:0]  prog_sel, prog_rpt, data_addr;
  logic [63:0] data_wdata;
  logic        core_valid, busy, done, err;
  logic [5:0]  core_opmode;
  logic [63:0] core_data;
  logic [2:0]  pc;

  int checks = 0;
  int errors = 0;

  xood_cmd_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .eph1        (eph1),
    .reset_n     (reset_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_opmode (prog_opmode),
    .prog_sel    (prog_sel),
    .prog_rpt    (prog_rpt),
    .prog_last   (prog_last),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .start       (start),
    .abort       (abort),
`ifdef XOOD_SEQ_LOOP_EN
    .loop_mode   (loop_mode),
`endif
    .core_ready  (core_ready),
    .core_valid  (core_valid),
    .core_opmode (core_opmode),
    .core_data   (core_data),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .err         (err)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic set_cmd(input int a, input int op, input int sel, input int rpt, input bit last);
    prog_addr = 3'(a); prog_opmode = 6'(op); prog_sel = 4'(sel);
    prog_rpt = 4'(rpt); prog_last = last;
  endtask

  task automatic write_cmd(input int a, input int op, input int sel, input int rpt, input bit last);
    set_cmd(a, op, sel, rpt, last);
    prog_we = 1'b1; tick(); prog_we = 1'b0;
  endtask

  task automatic write_data(input int a, input logic [63:0] d);
    data_addr = 4'(a); data_wdata = d;
    data_we = 1'b1; tick(); data_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", core_valid); end
    checks++; if (core_opmode !== 6'd0) begin errors++; $display("FAIL reset_opmode: got %0d want 0", core_opmode); end
    checks++; if (core_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", core_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (pc !== 3'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    reset_n = 1'b1;
    tick();
  endtask

  // Entry 0 written in the same cycle as start: FETCH must see the new entry.
  task automatic test_single();
    write_data(1, D1);
    write_data(0, D0);
    core_ready = 1'b1;
    set_cmd(0, 1, 1, 0, 1'b1);
    prog_we = 1'b1; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL single_fetch_valid: got %0b want 0", core_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", busy); end
    tick();
    checks++; if (core_valid !== 1'b1) begin errors++; $display("FAIL single_beat_valid: got %0b want 1", core_valid); end
    checks++; if (core_opmode !== 6'd1) begin errors++; $display("FAIL single_opmode: got %0d want 1", core_opmode); end
    checks++; if (core_data !== D1) begin errors++; $display("FAIL single_data: got %h want %h", core_data, D1); end
    tick();
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL single_post_valid: got %0b want 0", core_valid); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %0b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %0b want 0", busy); end
  endtask

  task automatic test_repeat();
    logic        vld_e, done_e;
    logic [5:0]  op_e;
    logic [63:0] d_e;
    write_data(2, D2);
    write_data(3, D3);
    write_cmd(0, 3, 2, 2, 1'b0);
    write_cmd(1, 5, 3, 1, 1'b1);
    core_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      vld_e  = (k != 3) && (k != 6);
      done_e = (k == 6);
      op_e   = (k < 3) ? 6'd3 : 6'd5;
      d_e    = (k < 3) ? D2 : D3;
      checks++; if (core_valid !== vld_e) begin errors++; $display("FAIL repeat_valid[%0d]: got %0b want %0b", k, core_valid, vld_e); end
      checks++; if (done !== done_e) begin errors++; $display("FAIL repeat_done[%0d]: got %0b want %0b", k, done, done_e); end
      if (vld_e) begin
        checks++; if (core_opmode !== op_e) begin errors++; $display("FAIL repeat_opmode[%0d]: got %0d want %0d", k, core_opmode, op_e); end
        checks++; if (core_data !== d_e) begin errors++; $display("FAIL repeat_data[%0d]: got %h want %h", k, core_data, d_e); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int          b3, b5, done_k;
    logic [5:0]  snap_op;
    logic [63:0] snap_d;
    bit          rdy;
    b3 = 0; b5 = 0; done_k = -1; snap_op = '0; snap_d = '0;
    core_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 30; k++) begin
      rdy = !(k >= 1 && k <= 4);
      if (done) begin done_k = k; break; end
      if (k == 1) begin snap_op = core_opmode; snap_d = core_data; end
      if (k >= 2 && k <= 4) begin
        checks++; if (core_valid !== 1'b1 || core_opmode !== snap_op || core_data !== snap_d) begin
          errors++; $display("FAIL bp_stable[%0d]: got v=%0b op=%0d d=%h want v=1 op=%0d d=%h",
                             k, core_valid, core_opmode, core_data, snap_op, snap_d);
        end
      end
      if (core_valid && rdy) begin
        if (core_opmode == 6'd3) b3++;
        else if (core_opmode == 6'd5) b5++;
      end
      core_ready = rdy;
      tick();
    end
    core_ready = 1'b1;
    checks++; if (b3 !== 3) begin errors++; $display("FAIL bp_beats_op3: got %0d want 3", b3); end
    checks++; if (b5 !== 2) begin errors++; $display("FAIL bp_beats_op5: got %0d want 2", b5); end
    checks++; if (done_k !== 10) begin errors++; $display("FAIL bp_done_cycle: got %0d want 10", done_k); end
    tick();
  endtask

  task automatic test_abort();
    bit found, seen_done;
    found = 0; seen_done = 0;
    core_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (pc == 3'd1 && core_valid) begin found = 1; break; end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_entry1: got 0 want 1"); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b want 0", core_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    checks++; if (pc !== 3'd1) begin errors++; $display("FAIL abort_pc: got %0d want 1", pc); end
    for (int k = 0; k < 3; k++) begin
      if (done) seen_done = 1;
      tick();
    end
    checks++; if (seen_done) begin errors++; $display("FAIL abort_no_done: got 1 want 0"); end
  endtask

  task automatic test_write_busy();
    bit got_done;
    write_data(4, D4);
    write_cmd(0, 4, 4, 3, 1'b1);
    core_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    data_addr = 4'd4; data_wdata = BAD; data_we = 1'b1;
    tick();
    data_we = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_err_set: got %0b want 1", err); end
    checks++; if (core_data !== D4) begin errors++; $display("FAIL wb_data_hold: got %h want %h", core_data, D4); end
    core_ready = 1'b1;
    got_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin got_done = 1; break; end
      tick();
    end
    checks++; if (!got_done) begin errors++; $display("FAIL wb_done_first: got 0 want 1"); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_err_sticky: got %0b want 1", err); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wb_err_clear: got %0b want 0", err); end
    tick();
    checks++; if (core_data !== D4) begin errors++; $display("FAIL wb_table_kept: got %h want %h", core_data, D4); end
    got_done = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin got_done = 1; break; end
      tick();
    end
    checks++; if (!got_done) begin errors++; $display("FAIL wb_done_second: got 0 want 1"); end
    tick();
  endtask

  task automatic test_end_of_table();
    int         beats, done_pc;
    logic [5:0] last_op;
    beats = 0; done_pc = -1; last_op = '0;
    for (int i = 0; i < DEPTH; i++) write_cmd(i, i, 0, 0, 1'b0);
    loop_mode = 1'b0;
    core_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin done_pc = int'(pc); break; end
      if (core_valid && core_ready) begin beats++; last_op = core_opmode; end
      tick();
    end
    checks++; if (beats !== 8) begin errors++; $display("FAIL eot_beats: got %0d want 8", beats); end
    checks++; if (last_op !== 6'd7) begin errors++; $display("FAIL eot_last_op: got %0d want 7", last_op); end
    checks++; if (done_pc !== 7) begin errors++; $display("FAIL eot_done_pc: got %0d want 7", done_pc); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eot_idle: got %0b want 0", busy); end
  endtask

`ifdef XOOD_SEQ_LOOP_EN
  task automatic test_loop();
    int         dones;
    bit         busy_ok, wrap;
    logic [2:0] prev_pc;
    dones = 0; busy_ok = 1; wrap = 0; prev_pc = '0;
    loop_mode = 1'b1;
    core_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (done) dones++;
      if (!busy) busy_ok = 0;
      if (prev_pc == 3'd7 && pc == 3'd0) wrap = 1;
      prev_pc = pc;
      tick();
    end
    checks++; if (dones !== 2) begin errors++; $display("FAIL loop_dones: got %0d want 2", dones); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL loop_busy: got 0 want 1"); end
    checks++; if (!wrap) begin errors++; $display("FAIL loop_wrap: got 0 want 1"); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_abort: got %0b want 0", busy); end
    loop_mode = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0; prog_we = 1'b0; prog_last = 1'b0; data_we = 1'b0;
    start = 1'b0; abort = 1'b0; core_ready = 1'b0; loop_mode = 1'b0;
    prog_addr = '0; prog_opmode = '0; prog_sel = '0; prog_rpt = '0;
    data_addr = '0; data_wdata = '0;
    test_reset();
    test_single();
    test_repeat();
    test_backpressure();
    test_abort();
    test_write_busy();
    test_end_of_table();
`ifdef XOOD_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
